// File: rtl/display_pkg.sv
// Shared types and constants for the BCD display sequencer.
// The saturation threshold comes from pow10() so DIGITS can be retuned in one place.
package display_pkg;

    localparam int DIGITS_DEF = 6;
    localparam int BCD_W      = 4 * DIGITS_DEF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SAT,
        DONE
    } state_e;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/refresh_tick.sv
// Free-running refresh slot counter; o_Tick marks the wrap cycle of each slot.
module refresh_tick #(
    parameter int REFRESH_CYC = 5_000_000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    output logic o_Tick
);

    localparam int CW = $clog2(REFRESH_CYC);

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap   = (cnt_q == CW'(REFRESH_CYC - 1));
    assign o_Tick = wrap;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else if (wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Captures the newest binary value and converts it to BCD with a serial double-dabble
// engine, publishing the digits at most once per refresh slot (or on a forced request).
module bcd_display_ctrl
    import display_pkg::*;
#(
    parameter int IN_W        = 33,
    parameter int DIGITS      = DIGITS_DEF,
    parameter int REFRESH_CYC = 5_000_000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Valid,
    input  logic [IN_W-1:0]       i_Num,
    input  logic                  i_Force,
    output logic [4*DIGITS-1:0]   o_Digits,
    output logic                  o_Ovf,
    output logic                  o_Update,
    output logic                  o_Busy
);

    localparam int          NB_W   = 4 * DIGITS;
    localparam int          IW     = $clog2(IN_W + 1);
    localparam logic [63:0] SAT_TH = pow10(DIGITS);

    state_e                 state_q, state_d;
    logic [IN_W-1:0]        hold_q;
    logic                   pending_q, force_q;
    logic [IN_W-1:0]        shift_q, shift_d;
    logic [NB_W-1:0]        bcd_q, bcd_d, bcd_adj;
    logic                   ovf_q, ovf_d;
    logic [IW-1:0]          iter_q, iter_d;
    logic [NB_W-1:0]        digits_q;
    logic                   ovf_out_q;
    logic                   tick, start, sat;
    logic [NB_W+IN_W-1:0]   dd_shifted;

    refresh_tick #(.REFRESH_CYC(REFRESH_CYC)) u_tick (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .o_Tick (tick)
    );

    assign start = (state_q == IDLE) && (tick || force_q) && pending_q;
    assign sat   = (64'(hold_q) >= SAT_TH);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign dd_shifted = {bcd_adj, shift_q} << 1;

    // Capture is independent of FSM state; a new value in the start cycle re-arms pending.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hold_q    <= '0;
            pending_q <= 1'b0;
            force_q   <= 1'b0;
        end else begin
            if (i_Valid) begin
                hold_q <= i_Num;
            end
            if (i_Valid) begin
                pending_q <= 1'b1;
            end else if (start) begin
                pending_q <= 1'b0;
            end
            if (i_Force) begin
                force_q <= 1'b1;
            end else if (start) begin
                force_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            iter_q    <= '0;
            digits_q  <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            iter_q  <= iter_d;
            if (state_q == DONE) begin
                digits_q  <= bcd_q;
                ovf_out_q <= ovf_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = sat ? SAT : SHIFT;
            SHIFT:   if (iter_q == '0) state_d = DONE;
            SAT:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = hold_q;
                    if (!sat) begin
                        bcd_d  = '0;
                        ovf_d  = 1'b0;
                        iter_d = IW'(IN_W - 1);
                    end
                end
            end
            SHIFT: begin
                {bcd_d, shift_d} = dd_shifted;
                iter_d           = iter_q - 1'b1;
            end
            SAT: begin
                for (int k = 0; k < DIGITS; k++) begin
                    bcd_d[k*4 +: 4] = 4'd9;
                end
                ovf_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_Update = (state_q == DONE);
        o_Busy   = (state_q != IDLE);
    end

    assign o_Digits = digits_q;
    assign o_Ovf    = ovf_out_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl with a short refresh slot.
module tb_bcd_display_ctrl;

    localparam int IN_W   = 33;
    localparam int DIG    = display_pkg::DIGITS_DEF;
    localparam int NB     = display_pkg::BCD_W;
    localparam int REFR   = 64;

    logic            i_Clk, i_Rst, i_Valid, i_Force;
    logic [IN_W-1:0] i_Num;
    logic [NB-1:0]   o_Digits;
    logic            o_Ovf, o_Update, o_Busy;

    int total = 0;
    int bad   = 0;

    bcd_display_ctrl #(.IN_W(IN_W), .DIGITS(DIG), .REFRESH_CYC(REFR)) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Valid  (i_Valid),
        .i_Num    (i_Num),
        .i_Force  (i_Force),
        .o_Digits (o_Digits),
        .o_Ovf    (o_Ovf),
        .o_Update (o_Update),
        .o_Busy   (o_Busy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [IN_W-1:0] num;
        logic [NB-1:0]   dig;
        logic            ovf;
        int              lat;
    } vec_t;

    vec_t tbl[10];

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Reference: decimal digits by repeated division, saturating at 10**DIG.
    function automatic void ref_model(input longint unsigned v, output logic [NB-1:0] d,
                                      output logic ovf);
        longint unsigned lim;
        lim = 1;
        for (int k = 0; k < DIG; k++) lim = lim * 10;
        d = '0;
        if (v >= lim) begin
            for (int k = 0; k < DIG; k++) d[k*4 +: 4] = 4'd9;
            ovf = 1'b1;
        end else begin
            ovf = 1'b0;
            for (int k = 0; k < DIG; k++) begin
                d[k*4 +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
    endfunction

    // Forced conversion; lat = cycles from first busy sample to the update pulse.
    task automatic run_conv(input logic [IN_W-1:0] num, input string tag,
                            output logic [NB-1:0] d, output logic ovf, output int lat);
        int busy_at, upd_at;
        i_Valid = 1'b1; i_Num = num; i_Force = 1'b1;
        step();
        i_Valid = 1'b0; i_Force = 1'b0;
        busy_at = -1; upd_at = -1;
        for (int n = 0; n < 120 && upd_at < 0; n++) begin
            step();
            if (o_Busy && busy_at < 0) busy_at = n;
            if (o_Update) upd_at = n;
        end
        if (upd_at < 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no update expected update within 120 cycles", tag);
            lat = -1;
        end else begin
            lat = upd_at - busy_at;
        end
        step();
        d = o_Digits;
        ovf = o_Ovf;
    endtask

    task automatic count_updates(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            step();
            if (o_Update) cnt++;
        end
    endtask

    initial begin
        logic [NB-1:0] d, ed;
        logic          ov, eov;
        int            lat, cnt, busy_at, upd_at;
        logic [IN_W-1:0] rv;

        tbl[0] = '{33'd123456,        24'h123456, 1'b0, 33};
        tbl[1] = '{33'd1000000,       24'h999999, 1'b1, 1};
        tbl[2] = '{33'h1_FFFF_FFFF,   24'h999999, 1'b1, 1};
        tbl[3] = '{33'd0,             24'h000000, 1'b0, 33};
        tbl[4] = '{33'd999999,        24'h999999, 1'b0, 33};
        tbl[5] = '{33'd1,             24'h000001, 1'b0, 33};
        tbl[6] = '{33'd42,            24'h000042, 1'b0, 33};
        tbl[7] = '{33'd100000,        24'h100000, 1'b0, 33};
        tbl[8] = '{33'd500005,        24'h500005, 1'b0, 33};
        tbl[9] = '{33'd1048575,       24'h999999, 1'b1, 1};

        i_Rst = 1'b1; i_Valid = 1'b0; i_Force = 1'b0; i_Num = '0;
        repeat (3) step();
        chk("rst_digits", o_Digits, 0);
        chk("rst_ovf",    o_Ovf,    0);
        chk("rst_update", o_Update, 0);
        chk("rst_busy",   o_Busy,   0);
        i_Rst = 1'b0;

        // Tick-driven conversion: must wait for the slot wrap.
        repeat (3) step();
        i_Valid = 1'b1; i_Num = 33'd123456;
        step();
        i_Valid = 1'b0;
        busy_at = -1; upd_at = -1;
        for (int n = 0; n < 200 && upd_at < 0; n++) begin
            step();
            if (o_Busy && busy_at < 0) busy_at = n;
            if (o_Update) upd_at = n;
        end
        chk("t1_waits_tick", (busy_at >= 40) ? 1 : 0, 1);
        chk("t1_latency", upd_at - busy_at, 33);
        step();
        chk("t1_digits", o_Digits, 24'h123456);
        chk("t1_ovf", o_Ovf, 0);

        // Three captures in one slot collapse into one conversion of the newest.
        step();
        i_Valid = 1'b1; i_Num = 33'd5; step();
        i_Num = 33'd7; step();
        i_Num = 33'd9; step();
        i_Valid = 1'b0;
        count_updates(130, cnt);
        chk("t3_update_count", cnt, 1);
        chk("t3_digits", o_Digits, 24'h000009);

        // Forced conversion, then no spurious update at later ticks.
        run_conv(33'd42, "t4", d, ov, lat);
        chk("t4_digits", d, 24'h000042);
        chk("t4_latency", lat, 33);
        count_updates(140, cnt);
        chk("t4_no_repeat", cnt, 0);

        foreach (tbl[i]) begin
            run_conv(tbl[i].num, $sformatf("vec%0d", i), d, ov, lat);
            chk($sformatf("vec%0d_digits", i), d, tbl[i].dig);
            chk($sformatf("vec%0d_ovf", i), ov, tbl[i].ovf);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
        end

        // New value arriving on the start cycle is kept for the next slot.
        i_Valid = 1'b1; i_Num = 33'd11; i_Force = 1'b1;
        step();
        i_Num = 33'd99; i_Force = 1'b0;
        step();
        i_Valid = 1'b0;
        count_updates(40, cnt);
        chk("t6_first_count", cnt, 1);
        chk("t6_first_digits", o_Digits, 24'h000011);
        upd_at = -1;
        for (int n = 0; n < 200 && upd_at < 0; n++) begin
            step();
            if (o_Update) upd_at = n;
        end
        chk("t6_second_seen", (upd_at >= 0) ? 1 : 0, 1);
        step();
        chk("t6_second_digits", o_Digits, 24'h000099);

        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 5)) step();
            case ($urandom_range(0, 3))
                0:       rv = IN_W'($urandom_range(0, 999));
                1:       rv = IN_W'($urandom_range(0, 999999));
                2:       rv = IN_W'($urandom_range(1000000, 1100000));
                default: rv = {1'($urandom), 32'($urandom)};
            endcase
            ref_model(longint'(rv), ed, eov);
            run_conv(rv, $sformatf("rnd%0d", r), d, ov, lat);
            chk($sformatf("rnd%0d_digits(%0d)", r, rv), d, ed);
            chk($sformatf("rnd%0d_ovf", r), ov, eov);
            chk($sformatf("rnd%0d_lat", r), lat, eov ? 1 : 33);
        end

        // Reset in the middle of a conversion aborts it with no update.
        i_Valid = 1'b1; i_Num = 33'd123456; i_Force = 1'b1;
        step();
        i_Valid = 1'b0; i_Force = 1'b0;
        busy_at = -1;
        for (int n = 0; n < 10 && busy_at < 0; n++) begin
            step();
            if (o_Busy) busy_at = n;
        end
        chk("t5_started", (busy_at >= 0) ? 1 : 0, 1);
        cnt = 0;
        repeat (10) begin
            step();
            if (o_Update) cnt++;
        end
        i_Rst = 1'b1;
        step();
        chk("t5_busy", o_Busy, 0);
        chk("t5_digits", o_Digits, 0);
        chk("t5_ovf", o_Ovf, 0);
        i_Rst = 1'b0;
        count_updates(200, lat);
        chk("t5_no_update", cnt + lat, 0);
        chk("t5_still_zero", o_Digits, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
